// File: rtl/pe_inst_seq.sv
// Per-PE instruction sequencer: loadable program memory, repeat count, gap-free issue,
// and data-memory enables delayed one cycle to line up with the memory's address register.
module pe_inst_seq #(
  parameter int INST_WIDTH    = 32,
  parameter int IM_ADDR_WIDTH = 5,
  parameter int LOOP_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [IM_ADDR_WIDTH-1:0] load_addr,
  input  logic [INST_WIDTH-1:0]    load_inst,
  input  logic                     start,
  input  logic [LOOP_WIDTH-1:0]    loop_cnt,
  output logic [INST_WIDTH-1:0]    inst_out,
  output logic                     dm_wren,
  output logic                     dm_rden,
  output logic                     busy,
  output logic                     done
);

  localparam int DEPTH   = 2 ** IM_ADDR_WIDTH;
  localparam int RE_BIT  = 27;
  localparam int WE_BIT  = 28;
  localparam int LAST_BIT = 31;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state_reg, state_next;
  logic [IM_ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [LOOP_WIDTH-1:0]    loops_reg, loops_next;
  logic                     drain_reg, drain_next;
  logic [INST_WIDTH-1:0]    inst_reg, inst_next;
  logic                     issue_v_reg, issue_v_next;
  logic                     done_reg, done_next;
  logic                     wren_reg, rden_reg;

  logic [INST_WIDTH-1:0]    imem [DEPTH];
  logic [INST_WIDTH-1:0]    fetch;

  // Program memory survives reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (load_en && state_reg == IDLE)
      imem[load_addr] <= load_inst;
  end

  assign fetch = imem[pc_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      loops_reg   <= '0;
      drain_reg   <= 1'b0;
      inst_reg    <= '0;
      issue_v_reg <= 1'b0;
      done_reg    <= 1'b0;
      wren_reg    <= 1'b0;
      rden_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      loops_reg   <= loops_next;
      drain_reg   <= drain_next;
      inst_reg    <= inst_next;
      issue_v_reg <= issue_v_next;
      done_reg    <= done_next;
      // Enables trail the issued word by one cycle.
      wren_reg    <= issue_v_reg & inst_reg[WE_BIT];
      rden_reg    <= issue_v_reg & inst_reg[RE_BIT];
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    loops_next   = loops_reg;
    drain_next   = drain_reg;
    inst_next    = '0;
    issue_v_next = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pc_next    = '0;
          loops_next = loop_cnt;
          state_next = RUN;
        end
      end
      RUN: begin
        inst_next    = fetch;
        issue_v_next = 1'b1;
        // The top address acts as an implicit LAST so the pc never wraps silently.
        if (fetch[LAST_BIT] || pc_reg == '1) begin
          if (loops_reg != '0) begin
            pc_next    = '0;
            loops_next = loops_reg - LOOP_WIDTH'(1);
          end else begin
            state_next = DRAIN;
            drain_next = 1'b0;
          end
        end else begin
          pc_next = pc_reg + IM_ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_reg) begin
          state_next = IDLE;
          drain_next = 1'b0;
          done_next  = 1'b1;
        end else begin
          drain_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign inst_out = inst_reg;
  assign dm_wren  = wren_reg;
  assign dm_rden  = rden_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_pe_inst_seq.sv
// Directed bench for pe_inst_seq: a reference program copy builds the expected
// per-cycle trace into a scoreboard queue, popped and compared once per clock.
module tb_pe_inst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_inst;
  logic        start;
  logic [7:0]  loop_cnt;
  logic [31:0] inst_out;
  logic        dm_wren, dm_rden, busy, done;

  pe_inst_seq #(.INST_WIDTH(32), .IM_ADDR_WIDTH(5), .LOOP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_inst(load_inst), .start(start), .loop_cnt(loop_cnt),
    .inst_out(inst_out), .dm_wren(dm_wren), .dm_rden(dm_rden),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        rden;
    logic        wren;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [32];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] mk(input bit last, input bit we, input bit re,
                                     input logic [7:0] waddr, input logic [7:0] raddr1,
                                     input logic [7:0] raddr0);
    logic [31:0] w;
    w = '0;
    w[31] = last; w[28] = we; w[27] = re;
    w[23:16] = waddr; w[15:8] = raddr1; w[7:0] = raddr0;
    return w;
  endfunction

  task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, j, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input int j, input exp_t e);
    chk({tag, ".inst"}, j, inst_out, e.inst);
    chk({tag, ".rden"}, j, {31'b0, dm_rden}, {31'b0, e.rden});
    chk({tag, ".wren"}, j, {31'b0, dm_wren}, {31'b0, e.wren});
    chk({tag, ".busy"}, j, {31'b0, busy}, {31'b0, e.busy});
    chk({tag, ".done"}, j, {31'b0, done}, {31'b0, e.done});
    $display("%s cycle %0d: inst=%h rden=%b wren=%b busy=%b done=%b", tag, j,
             inst_out, dm_rden, dm_wren, busy, done);
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] w);
    load_en = 1'b1; load_addr = a; load_inst = w;
    @(posedge clk); #1;
    load_en = 1'b0;
    mem[a] = w;
  endtask

  // One run: expected trace from the reference program, then cycle-by-cycle checks.
  // abort_j >= 0 asserts rst after that cycle; poke injects ignored requests mid-run.
  task automatic run(input string tag, input int lc, input int abort_j, input bit poke,
                     input bit ldstart, input logic [31:0] ldw);
    logic [31:0] seq[$];
    int          t;
    exp_t        e;
    if (ldstart) begin
      load_en = 1'b1; load_addr = 5'd0; load_inst = ldw;
      mem[0] = ldw;
    end
    for (int p = 0; p <= lc; p++) begin
      for (int pc = 0; pc < 32; pc++) begin
        seq.push_back(mem[pc]);
        if (mem[pc][31] || pc == 31) break;
      end
    end
    t = seq.size();
    for (int j = 0; j <= t + 2; j++) begin
      e.inst = (j >= 1 && j <= t) ? seq[j-1] : 32'h0;
      e.rden = (j >= 2 && j <= t + 1) ? seq[j-2][27] : 1'b0;
      e.wren = (j >= 2 && j <= t + 1) ? seq[j-2][28] : 1'b0;
      e.busy = (j <= t + 1);
      e.done = (j == t + 2);
      sb.push_back(e);
    end
    start = 1'b1; loop_cnt = lc[7:0];
    for (int j = 0; j <= t + 2; j++) begin
      @(posedge clk); #1;
      start = 1'b0; load_en = 1'b0;
      e = sb.pop_front();
      chk_all(tag, j, e);
      if (poke && j == 3) begin
        load_en = 1'b1; load_addr = 5'd1; load_inst = ~mem[1];
        start = 1'b1; loop_cnt = 8'd0;
      end
      if (j == abort_j) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        e = '0;
        chk_all({tag, ".rst"}, j + 1, e);
        sb.delete();
        return;
      end
    end
  endtask

  initial begin
    exp_t z;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_inst = '0;
    start = 1'b0; loop_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    z = '0;
    chk_all("reset", 0, z);
    rst = 1'b0;

    load(5'd0, mk(1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 8'h05));
    load(5'd1, mk(1'b0, 1'b1, 1'b0, 8'h09, 8'h22, 8'h33));
    load(5'd2, mk(1'b1, 1'b0, 1'b1, 8'h44, 8'h55, 8'h66));

    run("basic", 0, -1, 1'b0, 1'b0, 32'h0);
    run("loop",  2, -1, 1'b0, 1'b0, 32'h0);
    run("busy_req", 2, -1, 1'b1, 1'b0, 32'h0);
    run("after_req", 0, -1, 1'b0, 1'b0, 32'h0);
    run("rst_mid", 2, 2, 1'b0, 1'b0, 32'h0);
    run("rerun", 0, -1, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 32; i++)
      load(i[4:0], mk(1'b0, i[0], i[1], 8'(i + 100), 8'(i * 3), 8'(i)));
    run("implicit_last", 0, -1, 1'b0, 1'b0, 32'h0);

    run("load_start", 0, -1, 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b1, 8'hAA, 8'hBB, 8'hCC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pe_inst_seq.md
# pe_inst_seq

Instruction sequencer for one PE. It holds a small loadable program and issues one instruction word per cycle to the PE's data memory and ALU. It generates the data-memory write/read enables one cycle after each instruction word, matching the memory's registered-address pipeline. It supports a repeat count and reports completion with a `done` pulse.

## Interface
- `INST_WIDTH`, 32: instruction word width. Fixed fields:
  - [7:0] raddr0, [15:8] raddr1, [23:16] waddr
  - [26:24] reserved
  - [27] RE, [28] WE
  - [30:29] sel
  - [31] LAST
- `IM_ADDR_WIDTH`, 5: program memory depth is 2**IM_ADDR_WIDTH words.
- `LOOP_WIDTH`, 8: repeat-count width.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `load_en`  in  1  write `load_inst` into program memory at `load_addr`. Honoured only in IDLE.
- `load_addr`  in  IM_ADDR_WIDTH  program write address.
- `load_inst`  in  INST_WIDTH  program write data.
- `start`  in  1  begin execution. Honoured only in IDLE.
- `loop_cnt`  in  LOOP_WIDTH  extra passes; sampled with `start`. The program runs loop_cnt+1 times.
- `inst_out`  out  INST_WIDTH  issued instruction, registered. Zero when not issuing.
- `dm_wren`  out  1  data-memory write enable, registered.
- `dm_rden`  out  1  data-memory read enable, registered.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Program memory:
  - Distributed RAM with asynchronous read and synchronous write.
  - Not cleared by `rst`; contents persist across runs and resets.
  - `load_en` outside IDLE is ignored (no write).
- State machine: IDLE → RUN → DRAIN → IDLE.
- **IDLE**
  - `start`=1: pc←0, loops_left←loop_cnt, go to RUN.
  - `start` together with `load_en`: the write happens and the start is accepted. A write to address 0 is seen by the first fetch.
- **RUN**, every edge:
  - inst_out←imem[pc]; issue_v←1.
  - If imem[pc].LAST=1, or pc is at its maximum value (implicit LAST):
    - loops_left≠0: pc←0, loops_left−1.
    - loops_left=0: go to DRAIN with drain counter 0.
  - Otherwise pc←pc+1.
  - Issue is gap-free, including across loop wrap.
- **DRAIN**
  - Lasts 2 cycles. inst_out←0, issue_v←0.
  - On the second drain edge: state←IDLE, done←1 (high for one cycle), busy←0.
- Enable generation:
  - dm_rden(t+1) = issue_v(t) & inst_out(t)[27].
  - dm_wren(t+1) = issue_v(t) & inst_out(t)[28].
  - This places each enable in the cycle in which the data memory holds the latched address from that instruction.
- `start` while busy is ignored. It is not queued.
- Reset at any time, including mid-run:
  - State IDLE, pc=0, loops_left=0, issue_v=0.
  - `inst_out`=0, `dm_wren`=0, `dm_rden`=0, `busy`=0, `done`=0.
  - Any in-flight enables are dropped.

## Timing
- Edge E0 samples `start` in IDLE. From E0, busy=1.
- Instruction k of the flattened sequence (k=1..T) appears on `inst_out` after edge Ek.
- Its `dm_rden`/`dm_wren` appear after edge E(k+1).
- The data memory returns read data after edge E(k+2).
- T = N·(loop_cnt+1), where N is the program length up to and including LAST.
- DRAIN occupies edges E(T+1) and E(T+2). After E(T+2): busy=0 and done=1 for one cycle.
- The last write enable falls within busy.
- A new `start` is accepted in the cycle in which done=1.
- Minimum run is N=1, loop_cnt=0: done after E3.

## Test plan
- **Basic run:**
  - Stimulus: load 3 instructions — I0 RE=1 raddr0=5; I1 WE=1 waddr=9; I2 LAST=1 RE=1. Then start with loop_cnt=0.
  - Required: inst_out=I0/I1/I2 after E1/E2/E3. dm_rden=1 after E2 and E4; dm_wren=1 after E3. done after E5. busy high for exactly 5 cycles.
- **Looping:**
  - Stimulus: the same program with loop_cnt=2.
  - Required: 9 contiguous issues I0 I1 I2 I0 I1 I2 I0 I1 I2 with no bubble at the wraps. done after E11.
- **Ignored requests while busy:**
  - Stimulus: load_en to address 1, and start, both asserted mid-run.
  - Required: imem[1] unchanged (checked on the next run). No restart. done timing unchanged.
- **Reset mid-run:**
  - Stimulus: assert rst after E2 of a 9-issue run.
  - Required: the next cycle shows all outputs 0 and state IDLE. A following start re-runs from I0 using the unchanged program.
- **Implicit LAST:**
  - Stimulus: 32 words with LAST=0 everywhere, loop_cnt=0.
  - Required: 32 issues, then DRAIN. done after E34.
- **Load and start together:**
  - Stimulus: in IDLE, load_en to address 0 together with start.
  - Required: the first inst_out equals the newly written word.
